data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-addressed data memory that answers the datapath's load/store requests over a req/ack handshake with a configurable number of wait states. The datapath drives the address, write data and direction; this block performs the access, returns read data and pulses an acknowledge. It sits between the datapath's data-address/data-write outputs and its data-in mux input, and replaces the bench-driven constant data word with real storage.

## Interface

Parameters:
- N, 16, data and address width in bits.
- ADDR_W, 8, implemented address bits; depth is 2^ADDR_W words.
- WAIT, 1, wait-state cycles inserted before each access completes (0..15).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Mem_Req  input  1  request valid, sampled only in IDLE.
- Mem_Write  input  1  1 = store, 0 = load; sampled with Mem_Req.
- Mem_Addr  input  N  word address; sampled with Mem_Req.
- Mem_Wdata  input  N  store data; sampled with Mem_Req.
- Mem_Rdata  output  N  load result, registered; holds its value until the next completed load.
- Mem_Ack  output  1  one-cycle completion pulse.
- Mem_Err  output  1  qualifies Mem_Ack: the address was out of range.
- Mem_Busy  output  1  high whenever the state is not IDLE.
- Out_Port  output  N  memory-mapped output register (see Configuration).

## Operation

- States: IDLE, WAIT, ACK. Reset enters IDLE.
- IDLE: at an edge where Mem_Req=1, latch Mem_Write, Mem_Addr and Mem_Wdata, and load the wait counter with WAIT.
  - If WAIT=0, perform the access at that same edge and go to ACK.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each edge. At the edge where the counter equals 1, perform the access and go to ACK.
- ACK: Mem_Ack=1 for exactly this cycle, then IDLE unconditionally. Mem_Req is ignored in ACK.
- Access rules, using the latched fields:
  - In range (Mem_Addr[N-1:ADDR_W]==0):
    - Store: write the word; Mem_Rdata unchanged.
    - Load: Mem_Rdata <= mem[addr].
  - Out of range: Mem_Err=1 alongside Mem_Ack. A store is dropped; a load returns Mem_Rdata=0.
- Mem_Err is 0 whenever Mem_Ack is 0.
- Inputs changing after the sampling edge have no effect on the access in flight.

## Timing

- Reset values: Mem_Rdata=0, Mem_Ack=0, Mem_Err=0, Mem_Busy=0, Out_Port=0. Memory array contents are not cleared.
- Let E0 be the edge that samples Mem_Req in IDLE.
  - The access and Mem_Ack rise occur at edge E0+WAIT.
  - Mem_Ack falls at E0+WAIT+1.
  - Mem_Busy is high from E0 through E0+WAIT+1.
- Back-to-back requests (Mem_Req held high) are accepted every WAIT+2 cycles.
- Load data is valid in the same cycle Mem_Ack is high and is held afterwards.
- Reset asserted mid-operation: immediately return to IDLE with Mem_Ack=0. A pending store is discarded, never partially written. Mem_Rdata is cleared to 0.

## Configuration

- DMEM_MMIO_EN defined:
  - Address 16'hFFFF maps to Out_Port, bypassing the range check.
  - A store writes Out_Port at the access edge.
  - A load returns Out_Port in Mem_Rdata.
  - Mem_Err=0 for this address.
- DMEM_MMIO_EN undefined:
  - Out_Port is tied to 0.
  - 16'hFFFF is an ordinary out-of-range address (Mem_Err=1).

## Test plan

All scenarios use defaults (WAIT=1, ADDR_W=8).

1. Reset: assert Reset=0 asynchronously mid-cycle -> all outputs read 0 immediately, state IDLE.
2. Store 16'h00A5 to addr 16'h0012, then load 16'h0012 -> each Mem_Ack rises at E0+1 for one cycle; load gives Mem_Rdata=16'h00A5, Mem_Err=0.
3. Load addr 16'h0100 -> Mem_Ack=1, Mem_Err=1, Mem_Rdata=0. Store 16'hBEEF to 16'h0100, then load 16'h0000 -> returns the prior value (16'h0000 after fresh init), showing the dropped store did not alias to address 0.
4. Mem_Req held high with alternating store and load to 16'h0003 (data 16'h1234) -> acks every 3 cycles; Mem_Busy low only in the IDLE cycles; load returns 16'h1234.
5. Store 16'h1234 to 16'h0005 (prior value 16'h0077); pull Reset low during WAIT -> no Mem_Ack; after release, load 16'h0005 returns 16'h0077.
6. Store 16'h000F to 16'hFFFF:
   - With DMEM_MMIO_EN: Out_Port=16'h000F at the ack edge; a following load returns 16'h000F, Mem_Err=0.
   - Without DMEM_MMIO_EN: Mem_Err=1 and Out_Port stays 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering load/store
// requests over a req/ack handshake, with WAIT wait states per access.
// Optional feature macro: DMEM_MMIO_EN -- when defined, the all-ones address
// maps to the Out_Port register instead of the array (no range error).
module data_mem_responder #(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Mem_Req,
  input  logic         Mem_Write,
  input  logic [N-1:0] Mem_Addr,
  input  logic [N-1:0] Mem_Wdata,
  output logic [N-1:0] Mem_Rdata,
  output logic         Mem_Ack,
  output logic         Mem_Err,
  output logic         Mem_Busy,
  output logic [N-1:0] Out_Port
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                wr_q;
  logic [N-1:0]        addr_q;
  logic [N-1:0]        wdata_q;
  logic [N-1:0]        mem [0:DEPTH-1];

  logic                sel_write;
  logic [N-1:0]        sel_addr;
  logic [N-1:0]        sel_wdata;
  logic                access_now;
  logic                in_range;
  logic                is_mmio;
  logic                mem_we;
  logic [N-1:0]        rd_val;

  function automatic logic addr_in_range(input logic [N-1:0] a);
    return (a[N-1:ADDR_W] == '0);
  endfunction

  // With zero wait states the access uses the live inputs at the sampling
  // edge; otherwise it uses the fields latched when the request was taken.
  always_comb begin
    if (state == S_IDLE) begin
      sel_write = Mem_Write;
      sel_addr  = Mem_Addr;
      sel_wdata = Mem_Wdata;
    end else begin
      sel_write = wr_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
    end
  end

  assign access_now = ((state == S_IDLE) && Mem_Req && (WAIT == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));
  assign in_range   = addr_in_range(sel_addr);
  // Reset gates the array write so a store caught by reset is never committed.
  assign mem_we     = access_now && sel_write && in_range && !is_mmio && Reset;
  assign Mem_Busy   = (state != S_IDLE);

`ifdef DMEM_MMIO_EN
  logic [N-1:0] out_q;

  assign is_mmio  = (sel_addr == {N{1'b1}});
  assign Out_Port = out_q;

  // Memory-mapped output register, written by a store to the all-ones address.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      out_q <= '0;
    end else if (access_now && sel_write && is_mmio) begin
      out_q <= sel_wdata;
    end
  end
`else
  assign is_mmio  = 1'b0;
  assign Out_Port = '0;
`endif

  // Load result selection: array word, MMIO register, or zero when out of range.
  always_comb begin
    rd_val = '0;
    if (in_range) rd_val = mem[sel_addr[ADDR_W-1:0]];
`ifdef DMEM_MMIO_EN
    if (is_mmio) rd_val = out_q;
`endif
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[sel_addr[ADDR_W-1:0]] <= sel_wdata;
  end

  // Request fields captured at the sampling edge; data path, no reset needed.
  always_ff @(posedge Clock) begin
    if ((state == S_IDLE) && Mem_Req) begin
      addr_q  <= Mem_Addr;
      wdata_q <= Mem_Wdata;
    end
  end

  // Handshake FSM with registered ack/err/rdata.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      Mem_Rdata <= '0;
      Mem_Ack   <= 1'b0;
      Mem_Err   <= 1'b0;
    end else begin
      Mem_Ack <= 1'b0;
      Mem_Err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Mem_Req) begin
            wr_q  <= Mem_Write;
            cnt   <= WAIT_CNT;
            state <= (WAIT == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACK;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (access_now) begin
        Mem_Ack <= 1'b1;
        Mem_Err <= !in_range && !is_mmio;
        if (!sel_write) Mem_Rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: transaction-level reference model checked
// every cycle, randomized traffic, and directed scenarios with literal values.
module tb_data_mem_responder;
  localparam int N      = 16;
  localparam int ADDR_W = 8;
  localparam int WAIT   = 1;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Mem_Req = 1'b0;
  logic         Mem_Write = 1'b0;
  logic [N-1:0] Mem_Addr = '0;
  logic [N-1:0] Mem_Wdata = '0;
  logic [N-1:0] Mem_Rdata;
  logic         Mem_Ack;
  logic         Mem_Err;
  logic         Mem_Busy;
  logic [N-1:0] Out_Port;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  data_mem_responder #(.N(N), .ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .Clock(Clock), .Reset(Reset), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write),
    .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata),
    .Mem_Ack(Mem_Ack), .Mem_Err(Mem_Err), .Mem_Busy(Mem_Busy), .Out_Port(Out_Port)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transactions scheduled by edge number.
  logic [N-1:0] m_mem [0:255];
  int           cyc = 0;
  int           e0 = 0;
  int           free_at = 0;
  bit           pend = 1'b0;
  bit           p_wr = 1'b0;
  logic [N-1:0] p_addr = '0;
  logic [N-1:0] p_data = '0;
  logic [N-1:0] x_rdata = '0;
  logic [N-1:0] x_out = '0;
  bit           x_ack = 1'b0;
  bit           x_err = 1'b0;
  bit           x_busy = 1'b0;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cyc = 0; free_at = 0; pend = 0;
      x_rdata = '0; x_out = '0; x_ack = 0; x_err = 0; x_busy = 0;
    end else begin
      cyc++;
      x_ack = 0;
      x_err = 0;
      if (cyc >= free_at && Mem_Req) begin
        e0 = cyc; free_at = cyc + WAIT + 2; pend = 1;
        p_wr = Mem_Write; p_addr = Mem_Addr; p_data = Mem_Wdata;
      end
      if (pend && cyc == e0 + WAIT) begin
        pend  = 0;
        x_ack = 1;
        if (MMIO && p_addr == 16'hFFFF) begin
          if (p_wr) x_out = p_data; else x_rdata = x_out;
        end else if (p_addr < 16'd256) begin
          if (p_wr) m_mem[p_addr[7:0]] = p_data; else x_rdata = m_mem[p_addr[7:0]];
        end else begin
          x_err = 1;
          if (!p_wr) x_rdata = '0;
        end
      end
      x_busy = (cyc <= free_at - 2);
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge Clock) begin
    #1;
    if (chk_en) begin
      chk("ack", Mem_Ack, x_ack);
      chk("err", Mem_Err, x_err);
      chk("busy", Mem_Busy, x_busy);
      chk("rdata", Mem_Rdata, x_rdata);
      chk("out_port", Out_Port, x_out);
    end
  end

  // One request with ack latency and pulse width checks.
  task automatic xact(input bit wr, input logic [N-1:0] a, input logic [N-1:0] d,
                      output logic [N-1:0] rd, output logic er);
    int n;
    @(negedge Clock);
    Mem_Req = 1; Mem_Write = wr; Mem_Addr = a; Mem_Wdata = d;
    @(posedge Clock); #1;
    Mem_Req = 0; Mem_Write = 1'($urandom); Mem_Addr = N'($urandom); Mem_Wdata = N'($urandom);
    n = 0;
    while (!Mem_Ack && n < 20) begin
      @(posedge Clock); #1; n++;
    end
    chk("ack_latency", n, 1);
    rd = Mem_Rdata;
    er = Mem_Err;
    @(posedge Clock); #1;
    chk("ack_fall", Mem_Ack, 0);
  endtask

  initial begin
    logic [N-1:0] rd;
    logic         er;

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_rdata", Mem_Rdata, 0);
    chk("rst_ack", Mem_Ack, 0);
    chk("rst_err", Mem_Err, 0);
    chk("rst_busy", Mem_Busy, 0);
    chk("rst_out", Out_Port, 0);
    @(negedge Clock);
    Reset = 1; chk_en = 1;

    // Known contents for every word.
    for (int i = 0; i < 256; i++) xact(1, 16'(i), 16'h0000, rd, er);

    // Store then load.
    xact(1, 16'h0012, 16'h00A5, rd, er);
    xact(0, 16'h0012, 16'h0000, rd, er);
    chk("ld_0012", rd, 16'h00A5);
    chk("ld_0012_err", er, 0);

    // Out-of-range load/store; dropped store must not alias to word 0.
    xact(0, 16'h0100, 16'h0000, rd, er);
    chk("oor_ld_err", er, 1);
    chk("oor_ld_data", rd, 16'h0000);
    xact(1, 16'h0100, 16'hBEEF, rd, er);
    chk("oor_st_err", er, 1);
    xact(0, 16'h0000, 16'h0000, rd, er);
    chk("alias_0000", rd, 16'h0000);

    // Back-to-back with Mem_Req held: store/load alternate to word 3.
    @(negedge Clock);
    Mem_Req = 1; Mem_Write = 1; Mem_Addr = 16'h0003; Mem_Wdata = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      chk("b2b_busy_hi", Mem_Busy, 1);
      Mem_Write = ~Mem_Write;
      @(posedge Clock); #1;
      chk("b2b_ack", Mem_Ack, 1);
      if (k % 2 == 1) chk("b2b_ld", Mem_Rdata, 16'h1234);
      @(posedge Clock); #1;
      chk("b2b_idle", Mem_Busy, 0);
      if (k == 3) Mem_Req = 0;
    end

    // Reset during WAIT discards the pending store.
    xact(1, 16'h0005, 16'h0077, rd, er);
    @(negedge Clock);
    Mem_Req = 1; Mem_Write = 1; Mem_Addr = 16'h0005; Mem_Wdata = 16'h1234;
    @(posedge Clock); #1;
    Mem_Req = 0;
    chk("pre_rst_busy", Mem_Busy, 1);
    #2 Reset = 0;
    #1;
    chk("mid_rst_busy", Mem_Busy, 0);
    chk("mid_rst_ack", Mem_Ack, 0);
    @(posedge Clock); #1;
    chk("mid_rst_noack", Mem_Ack, 0);
    @(negedge Clock);
    Reset = 1;
    xact(0, 16'h0005, 16'h0000, rd, er);
    chk("ld_0005_kept", rd, 16'h0077);

    // Asynchronous reset in an idle cycle clears held load data at once.
    xact(0, 16'h0012, 16'h0000, rd, er);
    chk("ld_0012_again", rd, 16'h00A5);
    @(posedge Clock);
    #3 Reset = 0;
    #1;
    chk("async_rst_rdata", Mem_Rdata, 0);
    chk("async_rst_busy", Mem_Busy, 0);
    @(negedge Clock);
    Reset = 1;

    // Randomized traffic, inputs changing every cycle, one reset pulse.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      Mem_Req   = ($urandom_range(0, 3) != 0);
      Mem_Write = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       Mem_Addr = 16'h0100 + 16'($urandom_range(0, 255));
        1:       Mem_Addr = 16'hFFFF;
        2:       Mem_Addr = 16'($urandom);
        default: Mem_Addr = 16'($urandom_range(0, 255));
      endcase
      Mem_Wdata = 16'($urandom);
      if (c == 1500) begin
        @(posedge Clock);
        #2 Reset = 0;
        @(negedge Clock);
        Reset = 1;
      end
    end
    @(negedge Clock);
    Mem_Req = 0;
    repeat (4) @(posedge Clock);

    // Memory-mapped output port.
    xact(1, 16'hFFFF, 16'h000F, rd, er);
    chk("mmio_st_err", er, MMIO ? 1'b0 : 1'b1);
    chk("mmio_out", Out_Port, MMIO ? 16'h000F : 16'h0000);
    xact(0, 16'hFFFF, 16'h0000, rd, er);
    chk("mmio_ld", rd, MMIO ? 16'h000F : 16'h0000);
    chk("mmio_ld_err", er, MMIO ? 1'b0 : 1'b1);

    repeat (2) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
